spi_nor_cmd_sequencer: RTL

Sequences complete SPI NOR flash transactions (read, page program, sector erase) on behalf of the APB-side controller. Sits between the APB slave front end and a byte-wide SPI shift engine. Owns chip select, write-enable insertion, CS deassert gaps and busy-status polling. One transaction in flight at a time.

---
 rtl/spi_nor_pkg.sv | 30 +++
 rtl/spi_nor_cmd_sequencer_if.sv | 24 ++
 rtl/spi_nor_gap_timer.sv | 24 ++
 rtl/spi_nor_cmd_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_nor_pkg.sv
// Shared encodings for the SPI NOR command sequencer: request ops, flash opcodes,
// sequencer states and frame kinds.
package spi_nor_pkg;

   typedef enum logic [1:0] {
      OP_READ    = 2'b00,
      OP_PROGRAM = 2'b01,
      OP_ERASE   = 2'b10,
      OP_RSVD    = 2'b11
   } op_t;

   localparam logic [7:0] CMD_WREN      = 8'h06;
   localparam logic [7:0] CMD_PP        = 8'h02;
   localparam logic [7:0] CMD_READ      = 8'h03;
   localparam logic [7:0] CMD_FAST_READ = 8'h0B;
   localparam logic [7:0] CMD_SE        = 8'h20;
   localparam logic [7:0] CMD_RDSR      = 8'h05;

   localparam int WIP_BIT = 0;

   typedef enum logic [3:0] {
      IDLE, CS_ASSERT, WREN, GAP, CMD, ADDR, DATA, CS_END, POLL_CMD, POLL_RD, RESP
   } state_t;

   // Which frame the next CS_ASSERT opens.
   typedef enum logic [1:0] {
      FRM_WREN, FRM_MAIN, FRM_POLL
   } frame_t;

endpackage

// File: rtl/spi_nor_cmd_sequencer_if.sv
// Request/response handshake between the APB front end (master) and the
// SPI NOR command sequencer (slave).
interface spi_nor_cmd_sequencer_if #(
   parameter int ADDR_W = 24
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_op, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/spi_nor_gap_timer.sv
// Loadable down-counter timing the chip-select high gap between frames.
// Loading on the cycle CS rises makes expired assert in the last high cycle.
module spi_nor_gap_timer #(
   parameter int CSH_CYCLES = 4
) (
   input  logic p_clk,
   input  logic p_reset_n,
   input  logic load,
   output logic expired
);
   logic [7:0] cnt;

   always_ff @(posedge p_clk or negedge p_reset_n) begin
      if (!p_reset_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= 8'(CSH_CYCLES - 1);
      end else if (cnt != 8'd0) begin
         cnt <= cnt - 8'd1;
      end
   end

   assign expired = (cnt == 8'd0);
endmodule

// File: rtl/spi_nor_cmd_sequencer.sv
// SPI NOR command sequencer: READ, PAGE PROGRAM and SECTOR ERASE with WREN and WIP polling.
// Build option SPI_NOR_FAST_READ_EN: READ uses FAST READ (0x0B) with one dummy byte.
module spi_nor_cmd_sequencer
   import spi_nor_pkg::*;
#(
   parameter int ADDR_W     = 24,
   parameter int CSH_CYCLES = 4,
   parameter int POLL_MAX   = 65535
) (
   input  logic                    p_clk,
   input  logic                    p_reset_n,
   spi_nor_cmd_sequencer_if.slave  bus,
   output logic                    sh_start,
   output logic [7:0]              sh_tx_byte,
   input  logic                    sh_done,
   input  logic [7:0]              sh_rx_byte,
   output logic                    s_css
);
`ifdef SPI_NOR_FAST_READ_EN
   localparam logic [7:0] RD_OPCODE    = CMD_FAST_READ;
   localparam logic [2:0] RD_DATA_LAST = 3'd4;
`else
   localparam logic [7:0] RD_OPCODE    = CMD_READ;
   localparam logic [2:0] RD_DATA_LAST = 3'd3;
`endif

   state_t            state;
   frame_t            frm;
   op_t               op;
   logic [ADDR_W-1:0] req_addr_w;
   logic [23:0]       addr_sr;
   logic [31:0]       wdata_sr;
   logic [2:0]        byte_cnt;
   logic [15:0]       poll_cnt;
   logic              wip;
   logic              frame_end;
   logic              gap_expired;
   logic [2:0]        data_last;

   function automatic logic [2:0] byte_inc(input logic [2:0] c);
      return (c == 3'd7) ? c : c + 3'd1;
   endfunction

   function automatic logic [15:0] poll_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   assign req_addr_w = bus.req_addr;
   assign data_last  = (op == OP_READ) ? RD_DATA_LAST : 3'd3;

   // Last sh_done of the current frame: CS rises and the gap timer loads on this edge.
   always_comb begin
      frame_end = 1'b0;
      if (sh_done) begin
         case (state)
            WREN, POLL_RD: frame_end = 1'b1;
            ADDR:          frame_end = (byte_cnt == 3'd2) && (op == OP_ERASE);
            DATA:          frame_end = (byte_cnt == data_last);
            default:       frame_end = 1'b0;
         endcase
      end
   end

   spi_nor_gap_timer #(.CSH_CYCLES(CSH_CYCLES)) u_gap (
      .p_clk    (p_clk),
      .p_reset_n(p_reset_n),
      .load     (frame_end),
      .expired  (gap_expired)
   );

   always_ff @(posedge p_clk or negedge p_reset_n) begin
      if (!p_reset_n) begin
         state         <= IDLE;
         frm           <= FRM_WREN;
         op            <= OP_READ;
         addr_sr       <= '0;
         wdata_sr      <= '0;
         byte_cnt      <= '0;
         poll_cnt      <= '0;
         wip           <= 1'b0;
         bus.req_ready <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
         sh_start      <= 1'b0;
         sh_tx_byte    <= '0;
         s_css         <= 1'b1;
      end else begin
         sh_start      <= 1'b0;
         bus.rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               bus.req_ready <= 1'b1;
               if (bus.req_valid && bus.req_ready) begin
                  bus.req_ready <= 1'b0;
                  op            <= op_t'(bus.req_op);
                  addr_sr       <= 24'(req_addr_w);
                  wdata_sr      <= bus.req_wdata;
                  byte_cnt      <= '0;
                  poll_cnt      <= '0;
                  wip           <= 1'b0;
                  bus.rsp_rdata <= '0;
                  bus.rsp_err   <= (op_t'(bus.req_op) == OP_RSVD);
                  case (op_t'(bus.req_op))
                     OP_READ: begin
                        frm <= FRM_MAIN; s_css <= 1'b0; state <= CS_ASSERT;
                     end
                     OP_PROGRAM, OP_ERASE: begin
                        frm <= FRM_WREN; s_css <= 1'b0; state <= CS_ASSERT;
                     end
                     default: state <= RESP;
                  endcase
               end
            end
            CS_ASSERT: begin
               sh_start <= 1'b1;
               byte_cnt <= '0;
               case (frm)
                  FRM_WREN: begin sh_tx_byte <= CMD_WREN; state <= WREN; end
                  FRM_POLL: begin sh_tx_byte <= CMD_RDSR; state <= POLL_CMD; end
                  default: begin
                     sh_tx_byte <= (op == OP_READ) ? RD_OPCODE :
                                   (op == OP_PROGRAM) ? CMD_PP : CMD_SE;
                     state      <= CMD;
                  end
               endcase
            end
            WREN: if (sh_done) begin s_css <= 1'b1; state <= CS_END; end
            CMD: if (sh_done) begin
               sh_start   <= 1'b1;
               sh_tx_byte <= addr_sr[23:16];
               addr_sr    <= addr_sr << 8;
               state      <= ADDR;
            end
            ADDR: if (sh_done) begin
               if (frame_end) begin
                  s_css <= 1'b1; state <= CS_END;
               end else if (byte_cnt == 3'd2) begin
                  sh_start   <= 1'b1;
                  sh_tx_byte <= (op == OP_PROGRAM) ? wdata_sr[31:24] : 8'h00;
                  wdata_sr   <= wdata_sr << 8;
                  byte_cnt   <= '0;
                  state      <= DATA;
               end else begin
                  sh_start   <= 1'b1;
                  sh_tx_byte <= addr_sr[23:16];
                  addr_sr    <= addr_sr << 8;
                  byte_cnt   <= byte_inc(byte_cnt);
               end
            end
            DATA: if (sh_done) begin
               // Under FAST READ the dummy byte falls off the top after four more shifts.
               if (op == OP_READ) bus.rsp_rdata <= {bus.rsp_rdata[23:0], sh_rx_byte};
               if (frame_end) begin
                  s_css <= 1'b1; state <= CS_END;
               end else begin
                  sh_start   <= 1'b1;
                  sh_tx_byte <= (op == OP_PROGRAM) ? wdata_sr[31:24] : 8'h00;
                  wdata_sr   <= wdata_sr << 8;
                  byte_cnt   <= byte_inc(byte_cnt);
               end
            end
            POLL_CMD: if (sh_done) begin
               sh_start <= 1'b1; sh_tx_byte <= 8'h00; state <= POLL_RD;
            end
            POLL_RD: if (sh_done) begin
               wip      <= sh_rx_byte[WIP_BIT];
               poll_cnt <= poll_inc(poll_cnt);
               s_css    <= 1'b1;
               state    <= CS_END;
            end
            CS_END, GAP: begin
               if (!gap_expired) begin
                  state <= GAP;
               end else begin
                  case (frm)
                     FRM_WREN: begin frm <= FRM_MAIN; s_css <= 1'b0; state <= CS_ASSERT; end
                     FRM_MAIN: begin
                        if (op == OP_READ) begin
                           state <= RESP;
                        end else begin
                           frm <= FRM_POLL; s_css <= 1'b0; state <= CS_ASSERT;
                        end
                     end
                     default: begin
                        if (!wip) begin
                           state <= RESP;
                        end else if ({16'd0, poll_cnt} >= 32'(POLL_MAX)) begin
                           bus.rsp_err <= 1'b1; state <= RESP;
                        end else begin
                           s_css <= 1'b0; state <= CS_ASSERT;
                        end
                     end
                  endcase
               end
            end
            RESP: begin
               bus.rsp_valid <= 1'b1;
               bus.req_ready <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
